// File: rtl/fbuf_write_arbiter.sv
// Framebuffer write-port arbiter: forwards bounds-checked pixel writes to
// BRAM port A and runs a full-frame clear sweep on request. Pixel writes
// that collide with a sweep or fall outside the frame are dropped and counted.
module fbuf_write_arbiter #(
  parameter int FRAME_WIDTH_SCALED = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter logic [FBUF_DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fbuf_en_wr,
  input  logic                       fbuf_wrea,
  input  logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  input  logic                       fbuf_rst_req_n,
  input  logic                       cnt_clr,
  output logic                       bram_en,
  output logic                       bram_we,
  output logic [FBUF_ADDR_WIDTH-1:0] bram_addr,
  output logic [FBUF_DATA_WIDTH-1:0] bram_din,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic [CNT_WIDTH-1:0]       busy_drop_cnt,
  output logic [CNT_WIDTH-1:0]       oor_drop_cnt
);

  localparam int unsigned NPIX = FRAME_WIDTH_SCALED * FRAME_HEIGHT_SCALED;
  // One extra bit so the range compare works even when NPIX == 2**FBUF_ADDR_WIDTH.
  localparam logic [FBUF_ADDR_WIDTH:0]   NPIX_EXT = (FBUF_ADDR_WIDTH+1)'(NPIX);
  localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(NPIX - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state, state_nxt;

  logic [FBUF_ADDR_WIDTH-1:0] sweep_cnt, sweep_nxt;
  logic                       wr, wr_nxt;
  logic [FBUF_ADDR_WIDTH-1:0] addr_nxt;
  logic [FBUF_DATA_WIDTH-1:0] din_nxt;
  logic                       busy_nxt, done_nxt;
  logic                       busy_inc, oor_inc;

  logic pix_req, clr_req, in_range, sweep_last;

  assign pix_req    = fbuf_en_wr & fbuf_wrea;
  assign clr_req    = ~fbuf_rst_req_n;
  assign in_range   = {1'b0, fbuf_addr} < NPIX_EXT;
  assign sweep_last = (sweep_cnt == LAST_ADDR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a clear request always (re)enters CLEAR; leave after the last address
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (!clr_req && sweep_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered BRAM/status outputs and counter strobes
  always_comb begin
    wr_nxt    = 1'b0;
    addr_nxt  = '0;
    din_nxt   = '0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    sweep_nxt = sweep_cnt;
    busy_inc  = 1'b0;
    oor_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          // Clear wins over a simultaneous pixel; that pixel counts as a busy drop.
          wr_nxt    = 1'b1;
          din_nxt   = CLEAR_VALUE;
          busy_nxt  = 1'b1;
          sweep_nxt = '0;
          busy_inc  = pix_req;
        end else if (pix_req) begin
          if (in_range) begin
            wr_nxt   = 1'b1;
            addr_nxt = fbuf_addr;
            din_nxt  = fbuf_data;
          end else begin
            oor_inc = 1'b1;
          end
        end
      end
      CLEAR: begin
        // Every pixel during a sweep is a busy drop, whatever its address.
        busy_inc = pix_req;
        if (clr_req) begin
          wr_nxt    = 1'b1;
          din_nxt   = CLEAR_VALUE;
          busy_nxt  = 1'b1;
          sweep_nxt = '0;
        end else if (sweep_last) begin
          done_nxt  = 1'b1;
          sweep_nxt = '0;
        end else begin
          wr_nxt    = 1'b1;
          addr_nxt  = sweep_cnt + 1'b1;
          din_nxt   = CLEAR_VALUE;
          busy_nxt  = 1'b1;
          sweep_nxt = sweep_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and sweep counter (sweep_cnt tracks the address on the bus)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr         <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      sweep_cnt  <= '0;
    end else begin
      wr         <= wr_nxt;
      bram_addr  <= addr_nxt;
      bram_din   <= din_nxt;
      clear_busy <= busy_nxt;
      clear_done <= done_nxt;
      sweep_cnt  <= sweep_nxt;
    end
  end

  assign bram_en = wr;
  assign bram_we = wr;

  // Saturating drop counters; cnt_clr takes priority over a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_drop_cnt <= '0;
      oor_drop_cnt  <= '0;
    end else if (cnt_clr) begin
      busy_drop_cnt <= '0;
      oor_drop_cnt  <= '0;
    end else begin
      if (busy_inc && !(&busy_drop_cnt)) busy_drop_cnt <= busy_drop_cnt + 1'b1;
      if (oor_inc && !(&oor_drop_cnt))   oor_drop_cnt  <= oor_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Scoreboard bench for fbuf_write_arbiter on a 4x3 frame. Stimulus pushes
// the expected BRAM writes (with the cycle they must appear in) and the
// expected clear_done cycles; a negedge monitor pops and compares them.
module tb_fbuf_write_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int NP = 12;
  localparam logic [DW-1:0] CV = 8'h5C;

  logic          clk, rst_n;
  logic          fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n, cnt_clr;
  logic [AW-1:0] fbuf_addr;
  logic [DW-1:0] fbuf_data;
  logic          bram_en, bram_we, clear_busy, clear_done;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [CW-1:0] busy_drop_cnt, oor_drop_cnt;

  fbuf_write_arbiter #(
    .FRAME_WIDTH_SCALED(4), .FRAME_HEIGHT_SCALED(3),
    .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW),
    .CLEAR_VALUE(CV), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea),
    .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data),
    .fbuf_rst_req_n(fbuf_rst_req_n), .cnt_clr(cnt_clr),
    .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .busy_drop_cnt(busy_drop_cnt), .oor_drop_cnt(oor_drop_cnt)
  );

  typedef struct packed {
    int          cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic        busy;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_on = 0;
  int  c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every BRAM write and every clear_done must match the head of its queue
  always @(negedge clk) begin
    wr_t e;
    if (mon_on) begin
      if (bram_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d", bram_addr, bram_din, cyc);
        end else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", bram_addr, e.addr);
          chk("wr_data", bram_din, e.data);
          chk("wr_busy", clear_busy, e.busy);
          chk("wr_en", bram_en, 1);
        end
      end else begin
        chk("idle_bus", {bram_en, bram_addr, bram_din}, 0);
      end
      if (clear_done) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: at cycle %0d", cyc);
        end else begin
          chk("done_cycle", cyc, dq.pop_front());
          chk("done_busy", clear_busy, 0);
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    fbuf_en_wr = 0; fbuf_wrea = 0; fbuf_addr = '0; fbuf_data = '0;
    fbuf_rst_req_n = 1; cnt_clr = 0;
  endtask

  task automatic pix(input int a, input int d);
    fbuf_en_wr = 1; fbuf_wrea = 1; fbuf_addr = AW'(a); fbuf_data = DW'(d);
  endtask

  task automatic push_wr(input int cc, input int a, input int d, input bit b);
    wr_t e;
    e.cyc = cc; e.addr = AW'(a); e.data = DW'(d); e.busy = b;
    wq.push_back(e);
  endtask

  // Sweep writes addr k in cycle c0+k
  task automatic push_sweep(input int c0, input int n);
    for (int k = 0; k < n; k++) push_wr(c0 + k, k, CV, 1'b1);
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin step(); n++; end
    chk("wait_reached", cyc, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, bram_en, 0);
    chk({tag, "_we"}, bram_we, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_din"}, bram_din, 0);
    chk({tag, "_busy"}, clear_busy, 0);
    chk({tag, "_done"}, clear_done, 0);
    chk({tag, "_bcnt"}, busy_drop_cnt, 0);
    chk({tag, "_ocnt"}, oor_drop_cnt, 0);
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    #22;
    chk_all_zero("reset");
    step();
    rst_n = 1;
    mon_on = 1;
    step();

    // Plain write: addr 5 data A7, one cycle later
    pix(5, 'hA7); push_wr(cyc + 1, 5, 'hA7, 0); step(); idle_in();
    // Enable without strobe is not a request
    step(); fbuf_en_wr = 1; fbuf_addr = 3; fbuf_data = 8'h11; step(); idle_in();
    // Out of range (addr == N) dropped, then last in-range address accepted
    pix(12, 'h22); step(); idle_in();
    chk("oor_after_one", oor_drop_cnt, 1);
    pix(11, 'h3C); push_wr(cyc + 1, 11, 'h3C, 0); step(); idle_in();
    step(); step();

    // Full sweep with three drops inside it, and a write in the clear_done cycle
    c = cyc;
    fbuf_rst_req_n = 0; push_sweep(c + 1, NP); dq.push_back(c + 13); step(); idle_in();
    wait_until(c + 2); pix(2, 'h10); step(); idle_in();
    wait_until(c + 4); pix(13, 'h20); step(); idle_in();
    wait_until(c + 6); pix(4, 'h30); step(); idle_in();
    wait_until(c + 13); pix(9, 'h66); push_wr(c + 14, 9, 'h66, 0); step(); idle_in();
    chk("busy_drops_3", busy_drop_cnt, 3);
    chk("oor_unchanged", oor_drop_cnt, 1);
    chk("busy_low_after", clear_busy, 0);

    // Restart: second request while addr 7 is on the bus
    step();
    c = cyc;
    fbuf_rst_req_n = 0; push_sweep(c + 1, 8); push_sweep(c + 9, NP); dq.push_back(c + 21);
    step(); idle_in();
    wait_until(c + 8); fbuf_rst_req_n = 0; step(); idle_in();
    wait_until(c + 23);
    chk("busy_after_restart", clear_busy, 0);

    // Async reset while addr 4 is on the bus: everything drops at once, no done
    c = cyc;
    fbuf_rst_req_n = 0; push_sweep(c + 1, 5); step(); idle_in();
    wait_until(c + 5);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk_all_zero("async_rst");
    step(); step();
    rst_n = 1;
    step();
    pix(7, 'h5A); push_wr(cyc + 1, 7, 'h5A, 0); step(); idle_in();
    step(); step();

    // Clear and pixel in the same IDLE cycle: clear wins, pixel is a busy drop
    c = cyc;
    fbuf_rst_req_n = 0; pix(3, 'h77); push_sweep(c + 1, NP); dq.push_back(c + 13);
    step(); idle_in();
    wait_until(c + 14);
    chk("simul_busy_drop", busy_drop_cnt, 1);
    chk("simul_oor", oor_drop_cnt, 0);

    // Saturation: 17 out-of-range writes on a 4-bit counter
    for (int i = 0; i < 17; i++) begin pix(12 + (i % 4), i); step(); end
    idle_in(); step();
    chk("oor_saturated", oor_drop_cnt, 15);
    // cnt_clr coinciding with an increment leaves zero
    pix(14, 0); cnt_clr = 1; step(); idle_in();
    chk("oor_cleared", oor_drop_cnt, 0);
    chk("busy_cleared", busy_drop_cnt, 0);

    step(); step(); step();
    chk("wr_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fbuf_write_arbiter.md
Name: fbuf_write_arbiter

Overview:
- Sits between the AXI4-Lite GPU register decoder and the framebuffer BRAM write port (port A).
- Forwards single-pixel write pulses to the BRAM and bounds-checks each address.
- On a framebuffer reset request, runs a clear engine that sweeps every pixel address with CLEAR_VALUE, one address per cycle.
- Drops and counts pixel writes that arrive during a clear or fall out of range; exposes busy/done status for the status register.

Parameters:
- FRAME_WIDTH_SCALED, 640, pixels per line
- FRAME_HEIGHT_SCALED, 480, lines per frame
- FBUF_ADDR_WIDTH, 19, BRAM address width; must hold FRAME_WIDTH_SCALED*FRAME_HEIGHT_SCALED-1
- FBUF_DATA_WIDTH, 8, pixel width
- CLEAR_VALUE, 0, pixel value written by the clear engine
- CNT_WIDTH, 16, width of drop counters

Ports:
- clk  in  1  AXI clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- fbuf_en_wr  in  1  pixel write enable from decoder
- fbuf_wrea  in  1  pixel write strobe from decoder
- fbuf_addr  in  FBUF_ADDR_WIDTH  pixel address
- fbuf_data  in  FBUF_DATA_WIDTH  pixel value
- fbuf_rst_req_n  in  1  active-low clear request (level, sampled each cycle)
- cnt_clr  in  1  synchronous clear of both drop counters
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  FBUF_ADDR_WIDTH  BRAM address
- bram_din  out  FBUF_DATA_WIDTH  BRAM write data
- clear_busy  out  1  high while the clear engine is sweeping
- clear_done  out  1  one-cycle pulse when a sweep completes
- busy_drop_cnt  out  CNT_WIDTH  pixel writes dropped because a clear was running
- oor_drop_cnt  out  CNT_WIDTH  pixel writes dropped because the address was out of range

Behaviour:
- Clock and reset: one clock, asynchronous active-low reset.
- Reset values: all outputs 0; FSM in IDLE; sweep counter 0.
- BRAM contents are not touched by reset. Reset mid-clear aborts the sweep immediately, with no clear_done pulse.
- N = FRAME_WIDTH_SCALED*FRAME_HEIGHT_SCALED.
- A pixel request is valid when fbuf_en_wr && fbuf_wrea.
- All outputs are registered. Latency from the input sampling edge T to the BRAM signals is 1 cycle (valid from T+1).
- FSM state IDLE:
  - fbuf_rst_req_n==0 at edge T -> CLEAR. In cycle T+1: addr 0, bram_en=bram_we=1, bram_din=CLEAR_VALUE.
  - Else a valid request with fbuf_addr < N -> bram_en=bram_we=1, bram_addr=fbuf_addr, bram_din=fbuf_data for exactly one cycle.
  - Valid request with fbuf_addr >= N -> no BRAM access; oor_drop_cnt += 1.
  - Otherwise bram_en=bram_we=0, bram_addr=0, bram_din=0.
- FSM state CLEAR:
  - Writes addr k in cycle T+1+k for k = 0..N-1; clear_busy=1 for cycles T+1..T+N.
  - After writing addr N-1 -> IDLE. In cycle T+N+1: clear_busy=0, clear_done=1 for one cycle, BRAM idle.
  - fbuf_rst_req_n==0 again during CLEAR -> the sweep restarts: the next cycle writes addr 0 and the sweep length is again N from that point.
  - A valid pixel request during CLEAR is never written; busy_drop_cnt += 1. This holds regardless of its address, and the out-of-range check is not applied.
- Simultaneous clear request and valid pixel request in IDLE: clear wins; the pixel is dropped and counted in busy_drop_cnt.
- A request arriving in the clear_done cycle is accepted normally, since the FSM is already in IDLE.
- Counters:
  - Saturate at all-ones with no wrap.
  - cnt_clr zeroes both counters on the next edge.
  - If cnt_clr coincides with an increment, the counter reads 0 afterwards.
- Arithmetic: the sweep counter is FBUF_ADDR_WIDTH bits; its terminal compare is against N-1 (constant). The range compare is unsigned.

Test Plan:
- W=4,H=3 (N=12), reset released, valid write addr 5 data 0xA7 at edge T -> cycle T+1: bram_we=1, bram_addr=5, bram_din=0xA7; cycle T+2: bram_we=0.
- N=12, valid write addr 12 -> no bram_we; oor_drop_cnt=1. Then a write to addr 11 -> accepted.
- N=12, fbuf_rst_req_n low 1 cycle at T -> bram_addr 0..11 with bram_din=CLEAR_VALUE in cycles T+1..T+12; clear_busy=1 throughout; clear_done=1 only at T+13.
- During a sweep, 3 valid pixel writes -> none reach BRAM; busy_drop_cnt=3. A second clear request at sweep addr 7 -> next write addr 0; clear_done after 12 further writes.
- rst_n asserted asynchronously at sweep addr 4 -> all outputs 0 immediately, no clear_done. After release, a pixel write works with 1-cycle latency.
- CNT_WIDTH=4, 17 out-of-range writes -> oor_drop_cnt=0xF. Then cnt_clr together with an increment -> 0.
